// File: rtl/m_cycleacc.sv
// m_cycleacc: 64-bit cycle/instruction accumulator with compare register,
// coherent lo/hi read via a shadow high word, and a registered timer interrupt.
module m_cycleacc #(
  parameter int HIGHLEVEL   = 0,
  parameter int NO_CYCLECNT = 0,
  parameter int CMPEN       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        corerunning,
  input  logic        add_en,
  input  logic [5:0]  delta,
  input  logic        rd_en,
  input  logic [1:0]  rd_sel,
  output logic        rd_ack,
  output logic [31:0] rd_dat,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_dat,
  output logic        timer_irq
);

  logic [63:0] cnt_q;
  logic [63:0] cmp_q;
  logic [63:0] cnt_next;
  logic [63:0] cmp_next;
  logic [63:0] cnt_sum;
  logic [31:0] shadow_hi;
  logic [31:0] inc_lo;
  logic [31:0] rd_word;
  logic        wr_cnt;
  logic        wr_cmp;
  logic        add_go;
  logic        ge;
  logic        irq_next;

  assign inc_lo = (NO_CYCLECNT != 0) ? 32'd1 : {26'd0, delta};
  assign wr_cnt = wr_en & ~wr_sel[1];
  assign wr_cmp = wr_en & wr_sel[1] & (CMPEN != 0);
  // A time write suppresses the add completely, carry included.
  assign add_go = add_en & corerunning & ~wr_cnt;

  generate
    if (HIGHLEVEL != 0) begin : g_beh
      assign cnt_sum = cnt_q + {32'd0, inc_lo};

      // Behavioural unsigned compare of the next-state values
      always_comb begin
        ge = (cnt_next >= cmp_next);
      end
    end else begin : g_map
      logic [32:0] lo_sum;
      logic [31:0] hi_sum;

      // Two 32-bit halves; the low-half carry feeds the high half in the same cycle.
      assign lo_sum  = {1'b0, cnt_q[31:0]} + {1'b0, inc_lo};
      assign hi_sum  = cnt_q[63:32] + {31'd0, lo_sum[32]};
      assign cnt_sum = {hi_sum, lo_sum[31:0]};

      // Compare as the carry-out of cnt_next + ~cmp_next + 1, rippled LSB first
      always_comb begin
        ge = 1'b1;
        for (int unsigned i = 0; i < 64; i++) begin
          ge = (cnt_next[i] & ~cmp_next[i]) | (~(cnt_next[i] ^ cmp_next[i]) & ge);
        end
      end
    end
  endgenerate

  // Next-state for time and compare registers; writes take priority over adds
  always_comb begin
    cnt_next = cnt_q;
    if (wr_cnt) begin
      if (wr_sel[0]) cnt_next[63:32] = wr_dat;
      else           cnt_next[31:0]  = wr_dat;
    end else if (add_go) begin
      cnt_next = cnt_sum;
    end
    cmp_next = cmp_q;
    if (wr_cmp) begin
      if (wr_sel[0]) cmp_next[63:32] = wr_dat;
      else           cmp_next[31:0]  = wr_dat;
    end
    irq_next = (CMPEN != 0) & ge;
  end

  // Read mux over pre-update state; the high time word comes from the shadow
  always_comb begin
    rd_word = '0;
    case (rd_sel)
      2'd0: rd_word = cnt_q[31:0];
      2'd1: rd_word = shadow_hi;
      2'd2: rd_word = (CMPEN != 0) ? cmp_q[31:0]  : '0;
      2'd3: rd_word = (CMPEN != 0) ? cmp_q[63:32] : '0;
      default: rd_word = '0;
    endcase
  end

  // State registers, read response and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      cmp_q     <= '1;
      shadow_hi <= '0;
      rd_ack    <= 1'b0;
      rd_dat    <= '0;
      timer_irq <= 1'b0;
    end else begin
      cnt_q     <= cnt_next;
      cmp_q     <= cmp_next;
      timer_irq <= irq_next;
      rd_ack    <= rd_en;
      rd_dat    <= rd_en ? rd_word : '0;
      if (rd_en && rd_sel == 2'd0) shadow_hi <= cnt_q[63:32];
    end
  end

endmodule

// File: tb/tb_m_cycleacc.sv
// Directed bench for m_cycleacc: default instance plus a behavioural
// instruction-counter instance sharing the same stimulus.
module tb_m_cycleacc;

  logic        clk = 1'b0;
  logic        rst;
  logic        corerunning;
  logic        add_en;
  logic [5:0]  delta;
  logic        rd_en;
  logic [1:0]  rd_sel;
  logic        rd_ack;
  logic [31:0] rd_dat;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [31:0] wr_dat;
  logic        timer_irq;
  logic        rd_ack_nc;
  logic [31:0] rd_dat_nc;
  logic        timer_irq_nc;

  int vectors = 0;
  int miscompares = 0;

  m_cycleacc dut (
    .clk(clk), .rst(rst), .corerunning(corerunning), .add_en(add_en), .delta(delta),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_dat(rd_dat),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_dat(wr_dat), .timer_irq(timer_irq)
  );

  m_cycleacc #(.HIGHLEVEL(1), .NO_CYCLECNT(1), .CMPEN(1)) dut_nc (
    .clk(clk), .rst(rst), .corerunning(corerunning), .add_en(add_en), .delta(delta),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_ack(rd_ack_nc), .rd_dat(rd_dat_nc),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_dat(wr_dat), .timer_irq(timer_irq_nc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_add(input logic [5:0] d);
    add_en = 1'b1;
    delta  = d;
    step();
    add_en = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [31:0] dat);
    wr_en  = 1'b1;
    wr_sel = sel;
    wr_dat = dat;
    step();
    wr_en  = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] sel, output logic [31:0] dat,
                         output logic [31:0] dat_nc, output logic ack_pre,
                         output logic ack_on, output logic ack_post);
    ack_pre = rd_ack;
    rd_en   = 1'b1;
    rd_sel  = sel;
    step();
    rd_en   = 1'b0;
    ack_on  = rd_ack;
    dat     = rd_dat;
    dat_nc  = rd_dat_nc;
    step();
    ack_post = rd_ack;
  endtask

  task automatic test_reset;
    logic [31:0] d, dn;
    logic a0, a1, a2;
    rst = 1'b1; corerunning = 1'b0; add_en = 1'b0; delta = '0;
    rd_en = 1'b0; rd_sel = '0; wr_en = 1'b0; wr_sel = '0; wr_dat = '0;
    step(); step();
    vectors++;
    if (rd_ack !== 1'b0 || rd_dat !== 32'h0 || timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got ack=%b dat=%h irq=%b want 0/0/0", rd_ack, rd_dat, timer_irq);
    end
    rst = 1'b0;
    step();
    corerunning = 1'b1;
    do_read(2'd0, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h0 || a1 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_time_lo got %h ack=%b want 0 ack=1", d, a1);
    end
    do_read(2'd2, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL reset_cmp_lo got %h want ffffffff", d);
    end
    do_read(2'd3, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL reset_cmp_hi got %h want ffffffff", d);
    end
  endtask

  task automatic test_accumulate;
    logic [31:0] d, dn;
    logic a0, a1, a2;
    do_add(6'd5);
    do_add(6'd63);
    do_add(6'd1);
    do_read(2'd0, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h45) begin
      miscompares++;
      $display("FAIL acc_lo got %h want 00000045", d);
    end
    vectors++;
    if (a0 !== 1'b0 || a1 !== 1'b1 || a2 !== 1'b0) begin
      miscompares++;
      $display("FAIL acc_ack_timing got %b%b%b want 010", a0, a1, a2);
    end
    do_read(2'd1, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h0 || a1 !== 1'b1 || a2 !== 1'b0) begin
      miscompares++;
      $display("FAIL acc_hi got %h ack=%b%b want 0 ack=10", d, a1, a2);
    end
  endtask

  task automatic test_carry;
    logic [31:0] d, dn;
    logic a0, a1, a2;
    do_write(2'd0, 32'hFFFF_FFF0);
    do_write(2'd1, 32'h0);
    do_add(6'h20);
    do_read(2'd0, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h10) begin
      miscompares++;
      $display("FAIL carry_lo got %h want 00000010", d);
    end
    do_read(2'd1, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL carry_hi got %h want 00000001", d);
    end
  endtask

  task automatic test_shadow;
    logic [31:0] d, dn;
    logic a0, a1, a2;
    do_write(2'd0, 32'hFFFF_FFFF);
    do_write(2'd1, 32'h1);
    do_read(2'd0, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL shadow_lo got %h want ffffffff", d);
    end
    do_add(6'd2);
    do_read(2'd1, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL shadow_hi got %h want 00000001", d);
    end
    do_read(2'd0, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL shadow_lo2 got %h want 00000001", d);
    end
    do_read(2'd1, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h2) begin
      miscompares++;
      $display("FAIL shadow_hi2 got %h want 00000002", d);
    end
  endtask

  task automatic test_irq;
    logic [31:0] d, dn;
    logic a0, a1, a2;
    do_write(2'd1, 32'h0);
    do_write(2'd0, 32'd98);
    do_write(2'd2, 32'd100);
    do_write(2'd3, 32'h0);
    vectors++;
    if (timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_below got %b want 0", timer_irq);
    end
    do_add(6'd2);
    vectors++;
    if (timer_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise got %b want 1", timer_irq);
    end
    step();
    vectors++;
    if (timer_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_level got %b want 1", timer_irq);
    end
    do_write(2'd3, 32'h1);
    vectors++;
    if (timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_fall got %b want 0", timer_irq);
    end
    do_read(2'd2, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'd100) begin
      miscompares++;
      $display("FAIL irq_cmp_lo got %h want 00000064", d);
    end
  endtask

  task automatic test_write_priority;
    logic [31:0] d, dn;
    logic a0, a1, a2;
    add_en = 1'b1; delta = 6'd7;
    wr_en = 1'b1; wr_sel = 2'd0; wr_dat = 32'h1234;
    step();
    add_en = 1'b0; wr_en = 1'b0;
    do_read(2'd0, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h1234) begin
      miscompares++;
      $display("FAIL wr_beats_add got %h want 00001234", d);
    end
    corerunning = 1'b0;
    do_add(6'd9);
    corerunning = 1'b1;
    do_read(2'd0, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h1234) begin
      miscompares++;
      $display("FAIL gated_add got %h want 00001234", d);
    end
    rd_en = 1'b1; rd_sel = 2'd0;
    wr_en = 1'b1; wr_sel = 2'd0; wr_dat = 32'hABCD;
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    vectors++;
    if (rd_ack !== 1'b1 || rd_dat !== 32'h1234) begin
      miscompares++;
      $display("FAIL rdwr_old got ack=%b dat=%h want 1/00001234", rd_ack, rd_dat);
    end
    step();
    do_read(2'd0, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'hABCD) begin
      miscompares++;
      $display("FAIL rdwr_new got %h want 0000abcd", d);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] d, dn;
    logic a0, a1, a2;
    do_write(2'd1, 32'hFFFF_FFFF);
    do_write(2'd0, 32'hFFFF_FFFE);
    vectors++;
    if (timer_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_irq_pre got %b want 1", timer_irq);
    end
    do_add(6'd5);
    vectors++;
    if (timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_irq_post got %b want 0", timer_irq);
    end
    do_add(6'd0);
    do_read(2'd0, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h3) begin
      miscompares++;
      $display("FAIL wrap_lo got %h want 00000003", d);
    end
    do_read(2'd1, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_hi got %h want 00000000", d);
    end
  endtask

  task automatic test_no_cyclecnt;
    logic [31:0] d, dn;
    logic a0, a1, a2;
    do_write(2'd0, 32'h0);
    do_write(2'd1, 32'h0);
    for (int i = 0; i < 10; i++) do_add(6'(3 * i + 1));
    do_read(2'd0, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'd145) begin
      miscompares++;
      $display("FAIL delta_sum got %0d want 145", d);
    end
    vectors++;
    if (dn !== 32'd10) begin
      miscompares++;
      $display("FAIL nc_count got %0d want 10", dn);
    end
    do_read(2'd1, d, dn, a0, a1, a2);
    vectors++;
    if (dn !== 32'h0) begin
      miscompares++;
      $display("FAIL nc_hi got %h want 00000000", dn);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_dat [4];
    exp_dat[0] = 32'd145;
    exp_dat[1] = 32'h0;
    exp_dat[2] = 32'd100;
    exp_dat[3] = 32'h1;
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      step();
      vectors++;
      if (rd_ack !== 1'b1 || rd_dat !== exp_dat[i]) begin
        miscompares++;
        $display("FAIL b2b_%0d got ack=%b dat=%h want 1/%h", i, rd_ack, rd_dat, exp_dat[i]);
      end
    end
    rd_en = 1'b0;
    step();
    vectors++;
    if (rd_ack !== 1'b0 || rd_dat !== 32'h0) begin
      miscompares++;
      $display("FAIL b2b_idle got ack=%b dat=%h want 0/0", rd_ack, rd_dat);
    end
  endtask

  task automatic test_reset_midread;
    logic [31:0] d, dn;
    logic a0, a1, a2;
    logic seen;
    seen = 1'b0;
    rd_en = 1'b1; rd_sel = 2'd2;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    seen = seen | rd_ack | rd_ack_nc;
    rd_en = 1'b0;
    step();
    seen = seen | rd_ack | rd_ack_nc;
    rst = 1'b0;
    step();
    seen = seen | rd_ack | rd_ack_nc;
    step();
    seen = seen | rd_ack | rd_ack_nc;
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_drop_ack got %b want 0", seen);
    end
    do_read(2'd0, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'h0 || dn !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_time got %h/%h want 0/0", d, dn);
    end
    do_read(2'd3, d, dn, a0, a1, a2);
    vectors++;
    if (d !== 32'hFFFF_FFFF || dn !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL rst_cmp_hi got %h/%h want ffffffff", d, dn);
    end
    vectors++;
    if (timer_irq !== 1'b0 || timer_irq_nc !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_irq got %b/%b want 0/0", timer_irq, timer_irq_nc);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_accumulate();
    test_carry();
    test_shadow();
    test_irq();
    test_write_priority();
    test_wrap();
    test_no_cyclecnt();
    test_back_to_back();
    test_reset_midread();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
